// File: rtl/dual_core_bus_arb.sv
// dual_core_bus_arb: registered 3-master bus arbiter with m2 priority, m0/m1 round-robin, bounded locking and ack timeout
module dual_core_bus_arb #(
    parameter int TIMEOUT  = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] m_req,
    input  logic [2:0] m_lock,
    input  logic       s_ack,
    output logic [2:0] gnt,
    output logic [2:0] hold_o,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] err_id
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic       rr_q, rr_d;
    logic [4:0] tcnt_q, tcnt_d;
    logic [3:0] lcnt_q, lcnt_d;
    logic       terr_q, terr_d;
    logic [1:0] err_id_q, err_id_d;
    logic       req_g, lock_g, at_limit;
    logic [2:0] others, win;

    function automatic logic [2:0] arb(input logic [2:0] r, input logic p);
        arb = r[2] ? 3'b100 : (r[0] && (!r[1] || !p)) ? 3'b001 : r[1] ? 3'b010 : 3'b000;
    endfunction

    always_comb begin
        req_g    = |(gnt_q & m_req);
        lock_g   = |(gnt_q & m_lock);
        at_limit = lock_g && (lcnt_q == 4'(LOCK_MAX - 1));
        others   = m_req & ~gnt_q;
        // a master that used up its lock sits out one arbitration if anyone else waits
        win      = arb((at_limit && |others) ? others : m_req, rr_q);
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        tcnt_d   = tcnt_q;
        lcnt_d   = lcnt_q;
        terr_d   = 1'b0;
        err_id_d = err_id_q;
        if (state_q == IDLE) begin
            if (|m_req) begin
                state_d = BUSY;
                gnt_d   = win;
                tcnt_d  = '0;
                lcnt_d  = '0;
                rr_d    = win[0] ? 1'b1 : win[1] ? 1'b0 : rr_q;
            end
        end else if (!req_g) begin
            state_d = IDLE;
            gnt_d   = '0;
            tcnt_d  = '0;
            lcnt_d  = '0;
        end else if (s_ack && lock_g && !at_limit) begin
            lcnt_d = lcnt_q + 4'd1;
            tcnt_d = '0;
        end else if (s_ack) begin
            state_d = (|win) ? BUSY : IDLE;
            gnt_d   = win;
            tcnt_d  = '0;
            lcnt_d  = '0;
            rr_d    = win[0] ? 1'b1 : win[1] ? 1'b0 : rr_q;
        end else if (tcnt_q == 5'(TIMEOUT - 1)) begin
            state_d  = IDLE;
            gnt_d    = '0;
            tcnt_d   = '0;
            lcnt_d   = '0;
            terr_d   = 1'b1;
            err_id_d = {gnt_q[2], gnt_q[1]};
            rr_d     = gnt_q[0] ? 1'b1 : gnt_q[1] ? 1'b0 : rr_q;
        end else begin
            tcnt_d = tcnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_q     <= 1'b0;
            tcnt_q   <= '0;
            lcnt_q   <= '0;
            terr_q   <= 1'b0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            tcnt_q   <= tcnt_d;
            lcnt_q   <= lcnt_d;
            terr_q   <= terr_d;
            err_id_q <= err_id_d;
        end
    end

    assign gnt         = gnt_q;
    assign hold_o      = m_req & ~gnt_q;
    assign busy        = (state_q == BUSY);
    assign timeout_err = terr_q;
    assign err_id      = err_id_q;
endmodule

// File: tb/tb_dual_core_bus_arb.sv
// tb_dual_core_bus_arb: directed table-driven bench plus hand sequences for timeout, abandon and async reset
module tb_dual_core_bus_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] m_req, m_lock;
    logic       s_ack;
    logic [2:0] gnt, hold_o;
    logic       busy, timeout_err;
    logic [1:0] err_id;
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic       ack;
        logic [2:0] e_gnt;
        logic       e_busy;
        logic [2:0] e_hold;
    } vec_t;

    vec_t vecs[23];

    dual_core_bus_arb #(.TIMEOUT(16), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_lock(m_lock), .s_ack(s_ack),
        .gnt(gnt), .hold_o(hold_o), .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // round-robin, m2 priority, lock limit, lock over m2, idle ack ignored
        vecs[0]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 3'b010};
        vecs[1]  = '{3'b011, 3'b000, 1'b1, 3'b010, 1'b1, 3'b001};
        vecs[2]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 3'b010};
        vecs[3]  = '{3'b011, 3'b000, 1'b0, 3'b010, 1'b1, 3'b001};
        vecs[4]  = '{3'b011, 3'b000, 1'b1, 3'b010, 1'b1, 3'b001};
        vecs[5]  = '{3'b101, 3'b000, 1'b0, 3'b001, 1'b1, 3'b100};
        vecs[6]  = '{3'b101, 3'b000, 1'b1, 3'b001, 1'b1, 3'b100};
        vecs[7]  = '{3'b011, 3'b000, 1'b1, 3'b100, 1'b1, 3'b011};
        vecs[8]  = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b011};
        vecs[9]  = '{3'b011, 3'b000, 1'b0, 3'b010, 1'b1, 3'b001};
        vecs[10] = '{3'b011, 3'b000, 1'b1, 3'b010, 1'b1, 3'b001};
        vecs[11] = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 3'b010};
        vecs[12] = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 3'b010};
        vecs[13] = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 3'b010};
        vecs[14] = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 3'b010};
        vecs[15] = '{3'b011, 3'b001, 1'b0, 3'b010, 1'b1, 3'b001};
        vecs[16] = '{3'b011, 3'b000, 1'b1, 3'b010, 1'b1, 3'b001};
        vecs[17] = '{3'b111, 3'b001, 1'b1, 3'b001, 1'b1, 3'b110};
        vecs[18] = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 3'b110};
        vecs[19] = '{3'b110, 3'b000, 1'b0, 3'b100, 1'b1, 3'b010};
        vecs[20] = '{3'b000, 3'b000, 1'b0, 3'b100, 1'b1, 3'b000};
        vecs[21] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[22] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000};

        rst = 1'b1; m_req = 3'b011; m_lock = '0; s_ack = 1'b0;
        #3;
        chk("reset gnt", {5'd0, gnt}, 8'h0);
        chk("reset hold", {5'd0, hold_o}, 8'h3);
        chk("reset busy", {7'd0, busy}, 8'h0);
        chk("reset terr", {7'd0, timeout_err}, 8'h0);
        chk("reset err_id", {6'd0, err_id}, 8'h0);
        step();
        rst = 1'b0;
        step();
        chk("first grant", {5'd0, gnt}, 8'h1);
        chk("first hold", {5'd0, hold_o}, 8'h2);

        for (int i = 0; i < 23; i++) begin
            m_req = vecs[i].req; m_lock = vecs[i].lock; s_ack = vecs[i].ack;
            #1;
            chk($sformatf("row%0d gnt", i), {5'd0, gnt}, {5'd0, vecs[i].e_gnt});
            chk($sformatf("row%0d busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
            chk($sformatf("row%0d hold", i), {5'd0, hold_o}, {5'd0, vecs[i].e_hold});
            chk($sformatf("row%0d terr", i), {7'd0, timeout_err}, 8'h0);
            step();
        end

        m_lock = '0; s_ack = 1'b0; m_req = 3'b010;
        step();
        m_req = 3'b011;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("tmo wait%0d gnt", i), {5'd0, gnt}, 8'h2);
            chk($sformatf("tmo wait%0d terr", i), {7'd0, timeout_err}, 8'h0);
            step();
        end
        chk("tmo gnt", {5'd0, gnt}, 8'h0);
        chk("tmo busy", {7'd0, busy}, 8'h0);
        chk("tmo terr", {7'd0, timeout_err}, 8'h1);
        chk("tmo err_id", {6'd0, err_id}, 8'h1);
        step();
        chk("post tmo gnt", {5'd0, gnt}, 8'h1);
        chk("post tmo terr", {7'd0, timeout_err}, 8'h0);
        chk("post tmo err_id", {6'd0, err_id}, 8'h1);

        m_req = 3'b001;
        step();
        m_req = 3'b000;
        #1;
        chk("abandon pre gnt", {5'd0, gnt}, 8'h1);
        step();
        chk("abandon gnt", {5'd0, gnt}, 8'h0);
        chk("abandon busy", {7'd0, busy}, 8'h0);
        chk("abandon terr", {7'd0, timeout_err}, 8'h0);

        m_req = 3'b010;
        step();
        chk("pre rst gnt", {5'd0, gnt}, 8'h2);
        m_req = 3'b011;
        rst = 1'b1;
        #1;
        chk("async rst gnt", {5'd0, gnt}, 8'h0);
        chk("async rst busy", {7'd0, busy}, 8'h0);
        chk("async rst hold", {5'd0, hold_o}, 8'h3);
        chk("async rst err_id", {6'd0, err_id}, 8'h0);
        step();
        rst = 1'b0;
        step();
        chk("post rst rr gnt", {5'd0, gnt}, 8'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
